// File: rtl/mul_ctrl.sv
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Execute-stage sequencer for the two-cycle Booth/Wallace
//            multiplier. It accepts one multiply-class instruction at a
//            time, starts the multiplier, and stalls the pipeline until the
//            product returns. It optionally accumulates into HI/LO, then
//            issues a single-cycle HI/LO or GPR write. A pipeline flush
//            cancels the multiplier and suppresses all writes.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   MUL_ACC_EN  defined   -> MADD/MADDU/MSUB/MSUBU supported (ACC state, R reg)
//               undefined -> ops 2..5 are reported as illegal
// ----------------------------------------------------------------------------
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   OP_VALID, OP[2:0]        instruction present / opcode
//                            (0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB,
//                             5 MSUBU, 6 MUL, 7 reserved)
//   SRC_A, SRC_B             rs / rt operands (held while stalled)
//   HI_IN, LO_IN             forwarded HI/LO, used by the accumulate ops
//   FLUSH                    kill the in-flight instruction
//   MUL_START/CANCEL/SIGNED  multiplier controls
//   MUL_A, MUL_B             multiplier operands
//   MUL_RESULT, MUL_READY    multiplier product / product valid
//   STALL_REQ                hold IF/ID/EX
//   HILO_WE, HI_OUT, LO_OUT  HI/LO write strobe and data
//   GPR_WE, GPR_DATA         rd write strobe and data
//   OP_ILLEGAL               reserved op, or accumulate op when unsupported
// ============================================================================
`default_nettype none

module mul_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        OP_VALID,
  input  logic [2:0]  OP,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  input  logic        FLUSH,
  output logic        MUL_START,
  output logic        MUL_CANCEL,
  output logic        MUL_SIGNED,
  output logic [31:0] MUL_A,
  output logic [31:0] MUL_B,
  input  logic [63:0] MUL_RESULT,
  input  logic        MUL_READY,
  output logic        STALL_REQ,
  output logic        HILO_WE,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT,
  output logic        GPR_WE,
  output logic [31:0] GPR_DATA,
  output logic        OP_ILLEGAL
);

  localparam logic [2:0] OP_MUL_GPR = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
`ifdef MUL_ACC_EN
    S_ACC  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] p_q, p_d;
  logic        op_legal;
  logic        accept;
  logic        in_idle, in_wait, in_acc, in_done;
  logic [63:0] hilo_wdata;

`ifdef MUL_ACC_EN
  logic [63:0] r_q, r_d;
  logic        op_q_is_acc;
  // Ops 2..5 are exactly those with OP[2] != OP[1] (op 6 and 7 have both set).
  assign op_q_is_acc = op_q[2] ^ op_q[1];
`else
  // Accumulate inputs are only consumed when the accumulate ops exist.
  logic unused_acc_inputs;
  assign unused_acc_inputs = ^{HI_IN, LO_IN};
`endif

  always_comb begin
    op_legal = (OP != OP_RSVD);
`ifndef MUL_ACC_EN
    if ((OP >= 3'd2) && (OP <= 3'd5)) begin
      op_legal = 1'b0;
    end
`endif
  end

  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);
  assign in_done = (state_q == S_DONE);
`ifdef MUL_ACC_EN
  assign in_acc  = (state_q == S_ACC);
`else
  assign in_acc  = 1'b0;
`endif

  assign accept = in_idle & OP_VALID & ~FLUSH & op_legal;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      p_q     <= 64'd0;
`ifdef MUL_ACC_EN
      r_q     <= 64'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      p_q     <= p_d;
`ifdef MUL_ACC_EN
      r_q     <= r_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    p_d     = p_q;
`ifdef MUL_ACC_EN
    r_d     = r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = OP;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MUL_READY) begin
          p_d = MUL_RESULT;
`ifdef MUL_ACC_EN
          state_d = op_q_is_acc ? S_ACC : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MUL_ACC_EN
      S_ACC: begin
        // Ops 2/3 add, ops 4/5 subtract; wraps modulo 2^64.
        if (op_q[2:1] == 2'b01) begin
          r_d = {HI_IN, LO_IN} + p_q;
        end else begin
          r_d = {HI_IN, LO_IN} - p_q;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        // OP_VALID is still the retiring instruction here; never re-accept.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (FLUSH) begin
      state_d = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced low while RST is asserted so the
  // combinational controls cannot follow OP_VALID during reset.
  // --------------------------------------------------------------------------
`ifdef MUL_ACC_EN
  assign hilo_wdata = op_q_is_acc ? r_q : p_q;
`else
  assign hilo_wdata = p_q;
`endif

  always_comb begin
    MUL_START  = RST & accept;
    MUL_CANCEL = RST & FLUSH & ((in_idle & OP_VALID) | in_wait);
    OP_ILLEGAL = RST & in_idle & OP_VALID & ~op_legal;
    STALL_REQ  = RST & ~FLUSH & (accept | in_wait | in_acc);
    // Signed ops are the even opcodes 0, 2, 4, 6.
    MUL_SIGNED = RST & (in_idle ? (accept & ~OP[0]) : ~op_q[0]);
    MUL_A      = RST ? SRC_A : 32'd0;
    MUL_B      = RST ? SRC_B : 32'd0;
    HILO_WE    = RST & in_done & ~FLUSH & (op_q != OP_MUL_GPR);
    GPR_WE     = RST & in_done & ~FLUSH & (op_q == OP_MUL_GPR);
    HI_OUT     = HILO_WE ? hilo_wdata[63:32] : 32'd0;
    LO_OUT     = HILO_WE ? hilo_wdata[31:0]  : 32'd0;
    GPR_DATA   = GPR_WE  ? p_q[31:0]         : 32'd0;
  end

endmodule

`default_nettype wire
